mole_spawner: RTL and testbench

- Generates up to two active mole positions for the whack-a-mole game.
- Drives mole_pos1/mole_pos2: 4-bit, 0 = no mole, 1..8 = hole index. This is the format consumed by the LED output stage.
- Each slot runs a spawn/lifetime state machine paced by a game tick, with positions drawn from a free-running LFSR.
- Scores player hits and reports hits, misses and wrong presses as single-cycle pulses.

---
 rtl/mole_spawner_if.sv | 24 ++
 rtl/mole_spawner.sv | 248 ++++++++++++++++++++++++
 tb/tb_mole_spawner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_spawner_if.sv
// mole_spawner_if: game-side signal bundle for the mole spawner.
// The master drives pace, enable and player presses; the slave (the
// spawner) returns mole positions and the scoring pulses.
interface mole_spawner_if;
    logic       tick;
    logic       game_en;
    logic       hit_valid;
    logic [3:0] hit_pos;
    logic [3:0] mole_pos1;
    logic [3:0] mole_pos2;
    logic       hit_ok;
    logic       miss;
    logic       wrong;

    modport master (
        output tick, game_en, hit_valid, hit_pos,
        input  mole_pos1, mole_pos2, hit_ok, miss, wrong
    );

    modport slave (
        input  tick, game_en, hit_valid, hit_pos,
        output mole_pos1, mole_pos2, hit_ok, miss, wrong
    );
endinterface

// File: rtl/mole_spawner.sv
// mole_spawner: up to two whack-a-mole slots, each cycling
// IDLE -> GAP -> UP -> GAP ... on the game tick, with hole positions drawn
// from a free-running 8-bit LFSR. Scores presses as hit_ok / miss / wrong
// single-cycle pulses. Positions: 0 = no mole, 1..8 = hole index.
//
// Build option: define SECOND_MOLE_EN to enable slot 2 and the collision
// logic that keeps the two slots on different holes. Without it only slot 1
// exists and mole_pos2 is tied to 0.

// One mole slot: spawn/lifetime state machine. The owning block resolves
// which hole to load (i_load_pos) and whether a press hit this slot (i_hit).
module mole_slot #(
    parameter int LIFE_TICKS = 6,
    parameter int SPAWN_GAP  = 3,
    parameter int GAP_INIT   = 3,
    parameter int GAP_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_game_en,
    input  logic       i_hit,
    input  logic [3:0] i_load_pos,
    output logic [3:0] o_pos,
    output logic       o_spawn,
    output logic       o_expire
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [3:0]         r_life;
    logic [3:0]         w_life_nxt;
    logic [3:0]         r_pos;
    logic [3:0]         w_pos_nxt;

    // State, counters and the visible position register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_life  <= '0;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_life  <= w_life_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Next-state: counters only move on tick; a hit beats an expiring tick
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_life_nxt  = r_life;
        w_pos_nxt   = r_pos;
        o_spawn     = 1'b0;
        o_expire    = 1'b0;
        if (!i_game_en) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
            w_life_nxt  = '0;
            w_pos_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_W'(GAP_INIT);
                    w_pos_nxt   = '0;
                end
                S_GAP: begin
                    if (i_tick) begin
                        if (r_gap > GAP_W'(1)) begin
                            w_gap_nxt = r_gap - GAP_W'(1);
                        end else begin
                            w_state_nxt = S_UP;
                            w_pos_nxt   = i_load_pos;
                            w_life_nxt  = 4'(LIFE_TICKS);
                            w_gap_nxt   = '0;
                            o_spawn     = 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (i_hit) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_W'(SPAWN_GAP);
                        w_life_nxt  = '0;
                        w_pos_nxt   = '0;
                    end else if (i_tick) begin
                        if (r_life > 4'd1) begin
                            w_life_nxt = r_life - 4'd1;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = GAP_W'(SPAWN_GAP);
                            w_life_nxt  = '0;
                            w_pos_nxt   = '0;
                            o_expire    = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                    w_life_nxt  = '0;
                    w_pos_nxt   = '0;
                end
            endcase
        end
    end

    assign o_pos = r_pos;
endmodule

module mole_spawner #(
    parameter int          LIFE_TICKS   = 6,
    parameter int          SPAWN_GAP    = 3,
    parameter int          SLOT2_OFFSET = 2,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    mole_spawner_if.slave      io_bus
);
    // Gap counters are sized for the longest reload (slot 2's staggered start)
    localparam int GAP_MAX = SPAWN_GAP + SLOT2_OFFSET;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    logic [7:0] r_lfsr;
    logic       w_fb;
    logic [3:0] w_cand1;
    logic       w_press;
    logic [3:0] w_load1;
    logic [3:0] w_pos1;
    logic       w_spawn1;
    logic       w_expire1;
    logic       w_hit1;
    logic [3:0] w_pos2;
    logic       w_expire2;
    logic       w_hit2;
    logic       r_hit_ok;
    logic       r_miss;
    logic       r_wrong;

    // Fibonacci LFSR, taps 8,6,5,4; runs every cycle regardless of tick
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    assign w_cand1 = {1'b0, r_lfsr[2:0]} + 4'd1;
    // A press counts only with a nonzero hole; positions are nonzero only
    // while a slot is UP, so an equality match implies an UP slot.
    assign w_press = io_bus.hit_valid && (io_bus.hit_pos != 4'd0);
    assign w_hit1  = w_press && (io_bus.hit_pos == w_pos1);

`ifdef SECOND_MOLE_EN
    logic [3:0] w_cand2;
    logic [3:0] w_other2;
    logic [3:0] w_load2;
    logic       w_spawn2;

    // Step a colliding candidate to the next hole, wrapping 8 -> 1
    function automatic logic [3:0] f_bump(input logic [3:0] i_cand,
                                          input logic [3:0] i_other);
        if (i_cand != i_other) return i_cand;
        return (i_cand == 4'd8) ? 4'd1 : i_cand + 4'd1;
    endfunction

    assign w_cand2  = {1'b0, r_lfsr[5:3]} + 4'd1;
    // Slot 1 has priority on a simultaneous spawn and keeps its raw candidate
    assign w_load1  = w_spawn2 ? w_cand1 : f_bump(w_cand1, w_pos2);
    // Slot 2 avoids whatever slot 1 will show next cycle if it is loading now
    assign w_other2 = w_spawn1 ? w_load1 : w_pos1;
    assign w_load2  = f_bump(w_cand2, w_other2);
    assign w_hit2   = w_press && (io_bus.hit_pos == w_pos2);

    mole_slot #(
        .LIFE_TICKS (LIFE_TICKS),
        .SPAWN_GAP  (SPAWN_GAP),
        .GAP_INIT   (SPAWN_GAP + SLOT2_OFFSET),
        .GAP_W      (GAP_W)
    ) u_slot2 (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (io_bus.tick),
        .i_game_en  (io_bus.game_en),
        .i_hit      (w_hit2),
        .i_load_pos (w_load2),
        .o_pos      (w_pos2),
        .o_spawn    (w_spawn2),
        .o_expire   (w_expire2)
    );
`else
    assign w_load1   = w_cand1;
    assign w_pos2    = 4'd0;
    assign w_hit2    = 1'b0;
    assign w_expire2 = 1'b0;
`endif

    mole_slot #(
        .LIFE_TICKS (LIFE_TICKS),
        .SPAWN_GAP  (SPAWN_GAP),
        .GAP_INIT   (SPAWN_GAP),
        .GAP_W      (GAP_W)
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (io_bus.tick),
        .i_game_en  (io_bus.game_en),
        .i_hit      (w_hit1),
        .i_load_pos (w_load1),
        .o_pos      (w_pos1),
        .o_spawn    (w_spawn1),
        .o_expire   (w_expire1)
    );

    // Scoring pulses; a disabled game scores nothing, two escapes make one miss
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_ok <= 1'b0;
            r_miss   <= 1'b0;
            r_wrong  <= 1'b0;
        end else begin
            r_hit_ok <= io_bus.game_en && (w_hit1 || w_hit2);
            r_miss   <= io_bus.game_en && (w_expire1 || w_expire2);
            r_wrong  <= io_bus.game_en && w_press && !(w_hit1 || w_hit2);
        end
    end

    assign io_bus.mole_pos1 = w_pos1;
    assign io_bus.mole_pos2 = w_pos2;
    assign io_bus.hit_ok    = r_hit_ok;
    assign io_bus.miss      = r_miss;
    assign io_bus.wrong     = r_wrong;
endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: table-driven opening sequence, hand-written escape and
// hit-versus-expiry sequences, then random play, all checked cycle by cycle
// against a countdown model of the game rules.
module tb_mole_spawner;
    localparam int         LIFE = 3;
    localparam int         GAP  = 2;
    localparam int         OFF  = 2;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef SECOND_MOLE_EN
    localparam int NS = 2;
`else
    localparam int NS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_spawner_if bus();

    mole_spawner #(
        .LIFE_TICKS   (LIFE),
        .SPAWN_GAP    (GAP),
        .SLOT2_OFFSET (OFF),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per slot the shown hole (0 = none) and the number of
    // ticks left before the next event; waiting 0 with no mole means idle.
    int m_pos[2];
    int m_wait[2];
    int m_life[2];
    int m_lfsr;
    int e_ok, e_miss, e_wrong;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bump(input int c, input int o);
        if (c != o) return c;
        return (c == 8) ? 1 : c + 1;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit e, input bit hv, input int hp);
        bit press, any_hit, any_exp;
        bit h[2], sp[2];
        int np[2];
        int c1, c2, fb;
        if (r) begin
            for (int s = 0; s < 2; s++) begin
                m_pos[s] = 0; m_wait[s] = 0; m_life[s] = 0;
            end
            m_lfsr = SEED;
            e_ok = 0; e_miss = 0; e_wrong = 0;
            return;
        end
        c1 = (m_lfsr % 8) + 1;
        c2 = ((m_lfsr / 8) % 8) + 1;
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr * 2) + fb) % 256;
        if (!e) begin
            for (int s = 0; s < 2; s++) begin
                m_pos[s] = 0; m_wait[s] = 0; m_life[s] = 0;
            end
            e_ok = 0; e_miss = 0; e_wrong = 0;
            return;
        end
        press = hv && hp != 0;
        any_hit = 0;
        any_exp = 0;
        for (int s = 0; s < 2; s++) begin
            h[s]  = (s < NS) && press && m_pos[s] != 0 && hp == m_pos[s];
            sp[s] = 0;
            np[s] = m_pos[s];
            any_hit |= h[s];
        end
        for (int s = 0; s < NS; s++) begin
            if (m_pos[s] != 0) begin
                if (h[s]) begin
                    np[s] = 0; m_wait[s] = GAP;
                end else if (t) begin
                    m_life[s]--;
                    if (m_life[s] == 0) begin
                        np[s] = 0; m_wait[s] = GAP; any_exp = 1;
                    end
                end
            end else if (m_wait[s] == 0) begin
                m_wait[s] = (s == 0) ? GAP : GAP + OFF;
            end else if (t) begin
                m_wait[s]--;
                if (m_wait[s] == 0) sp[s] = 1;
            end
        end
        if (sp[0]) begin
            np[0] = (NS == 2 && !sp[1]) ? bump(c1, m_pos[1]) : c1;
            m_life[0] = LIFE;
        end
        if (sp[1]) begin
            np[1] = bump(c2, sp[0] ? np[0] : m_pos[0]);
            m_life[1] = LIFE;
        end
        m_pos[0] = np[0];
        m_pos[1] = np[1];
        e_ok    = any_hit;
        e_miss  = any_exp;
        e_wrong = press && !any_hit;
    endtask

    // One clock: drive, advance the model, sample 1 time unit after the edge
    task automatic cycle(input bit r, input bit t, input bit e, input bit hv, input int hp);
        logic [31:0] act, exp;
        rst           = r;
        bus.tick      = t;
        bus.game_en   = e;
        bus.hit_valid = hv;
        bus.hit_pos   = 4'(hp);
        model_step(r, t, e, hv, hp);
        @(posedge clk);
        #1;
        act = {21'd0, bus.mole_pos1, bus.mole_pos2, bus.hit_ok, bus.miss, bus.wrong};
        exp = 32'((m_pos[0] << 7) | (m_pos[1] << 3) | (e_ok << 2) | (e_miss << 1) | e_wrong);
        chk("model{pos1,pos2,ok,miss,wrong}", act, exp);
        if (bus.mole_pos1 != 0 && bus.mole_pos2 != 0)
            chk("distinct_pos", 32'(bus.mole_pos1 == bus.mole_pos2), 0);
    endtask

    // Press selector: 0 none, 1 slot 1's hole, 2 an empty hole, 3 hole 0
    function automatic int press_pos(input int sel);
        if (sel == 1) return m_pos[0];
        if (sel == 2) begin
            for (int hh = 1; hh <= 8; hh++)
                if (hh != m_pos[0] && hh != m_pos[1]) return hh;
        end
        return 0;
    endfunction

    // Three quiet clocks then a tick clock carrying an optional press
    task automatic period(input int sel);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, sel != 0, press_pos(sel));
    endtask

    typedef struct {
        bit t;
        bit e;
        int sel;
        bit up1;
        bit ok;
        bit ms;
        bit wr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 1, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 2, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 3, 1, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0};

        // Reset two cycles with the game enabled
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 1, 0, 0);
            chk("rst_pos1", 32'(bus.mole_pos1), 0);
            chk("rst_pos2", 32'(bus.mole_pos2), 0);
            chk("rst_pulses", {29'd0, bus.hit_ok, bus.miss, bus.wrong}, 0);
        end

        // Opening: spawn, hit, wrong press, null press, disable while UP
        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].t, tbl[i].e, tbl[i].sel != 0, press_pos(tbl[i].sel));
            chk($sformatf("tbl%0d_up1", i), 32'(bus.mole_pos1 != 0), 32'(tbl[i].up1));
            chk($sformatf("tbl%0d_hit_ok", i), 32'(bus.hit_ok), 32'(tbl[i].ok));
            chk($sformatf("tbl%0d_miss", i), 32'(bus.miss), 32'(tbl[i].ms));
            chk($sformatf("tbl%0d_wrong", i), 32'(bus.wrong), 32'(tbl[i].wr));
            if (tbl[i].up1) chk($sformatf("tbl%0d_range", i), 32'(bus.mole_pos1 <= 8), 1);
            if (!tbl[i].e) chk($sformatf("tbl%0d_pos2_off", i), 32'(bus.mole_pos2), 0);
        end

        // Escape: spawn after the 2nd tick, escape on the 3rd tick after it
        cycle(0, 0, 1, 0, 0);
        period(0);
        chk("spawn_t1_pos1", 32'(bus.mole_pos1), 0);
        period(0);
        chk("spawn_t2_up", 32'(bus.mole_pos1 != 0), 1);
        period(0);
        period(0);
        chk("life_t4_up", 32'(bus.mole_pos1 != 0), 1);
        chk("life_t4_miss", 32'(bus.miss), 0);
        period(0);
        chk("escape_pos1", 32'(bus.mole_pos1), 0);
        chk("escape_miss", 32'(bus.miss), 1);
        cycle(0, 0, 1, 0, 0);
        chk("escape_miss_width", 32'(bus.miss), 0);

        // Respawn, then hit on the tick that would expire it
        period(0);
        chk("regap_t1_pos1", 32'(bus.mole_pos1), 0);
        period(0);
        chk("respawn_up", 32'(bus.mole_pos1 != 0), 1);
        period(0);
        period(0);
        period(1);
        chk("hit_vs_expire_ok", 32'(bus.hit_ok), 1);
        chk("hit_vs_expire_miss", 32'(bus.miss), 0);
        chk("hit_vs_expire_pos1", 32'(bus.mole_pos1), 0);
        cycle(0, 0, 1, 0, 0);
        chk("hit_ok_width", 32'(bus.hit_ok), 0);
        period(0);
        chk("after_hit_t1_pos1", 32'(bus.mole_pos1), 0);
        period(0);
        chk("after_hit_t2_up", 32'(bus.mole_pos1 != 0), 1);

        // Random play against the model
        for (int n = 0; n < 4000; n++) begin
            bit r, t, e, hv;
            int hp;
            r  = ($urandom_range(0, 499) == 0);
            t  = ($urandom_range(0, 2) == 0);
            e  = ($urandom_range(0, 63) != 0);
            hv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) hp = m_pos[$urandom_range(0, 1)];
            else                           hp = $urandom_range(0, 15);
            cycle(r, t, e, hv, hp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
